// File: rtl/sramarb_pkg.sv
// rtl/sramarb_pkg.sv - shared types and constants for the ZBT SRAM arbiter
package sramarb_pkg;

    localparam int A_SIZE = 18;
    localparam int DQ_W   = 36;

    // 0 = mutator, 1 = collector
    typedef logic req_id_t;

    typedef enum logic [1:0] {IDLE, ISSUE, TURN} arb_state_t;

    // DQ bus driver class: who drives DQ three cycles after the accept
    typedef enum logic [1:0] {RD_A, RD_B, WR} dq_class_t;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic            bank;
        req_id_t         id;
        logic [DQ_W-1:0] wdata;
    } pipe_stage_t;

    function automatic dq_class_t dq_class(input logic is_wr, input logic is_bank_b);
        if (is_wr)
            return WR;
        else if (is_bank_b)
            return RD_B;
        else
            return RD_A;
    endfunction

endpackage

// File: rtl/sramarb_sel_m.sv
// rtl/sramarb_sel_m.sv - arbiter FSM with DQ turnaround insertion; SRAMARB_RR_EN selects round-robin
module sramarb_sel_m
    import sramarb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] we,
    input  logic [1:0] bank,
    output logic [1:0] gnt
);

    arb_state_t state_q, state_d;
    dq_class_t  last_class_q, last_class_d;
    req_id_t    winner;
    dq_class_t  cand_class;
    logic       grant_ok;

`ifdef SRAMARB_RR_EN
    req_id_t ptr_q, ptr_d;

    // On a tie the requester named by the pointer wins
    assign winner = (req == 2'b11) ? ptr_q : req[1];
    assign ptr_d  = grant_ok ? ~winner : ptr_q;
`else
    // Collector has fixed priority
    assign winner = req[1];
`endif

    assign cand_class = dq_class(we[winner], bank[winner]);

    // A candidate is held off only when the previous cycle accepted a different driver class
    assign grant_ok = !reset && (req != 2'b00)
                      && ((state_q != ISSUE) || (cand_class == last_class_q));

    assign last_class_d = grant_ok ? cand_class : last_class_q;

    // State register, class of the last accept and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_class_q <= RD_A;
`ifdef SRAMARB_RR_EN
            ptr_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_class_q <= last_class_d;
`ifdef SRAMARB_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    // Next state: ISSUE marks an accept this cycle, TURN a withheld class change
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (req != 2'b00) ? ISSUE : IDLE;
            ISSUE: begin
                if (req == 2'b00)
                    state_d = IDLE;
                else if (grant_ok)
                    state_d = ISSUE;
                else
                    state_d = TURN;
            end
            TURN:    state_d = (req != 2'b00) ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant output: one-hot to the winner when the access may go this cycle
    always_comb begin
        gnt = 2'b00;
        if (grant_ok)
            gnt[winner] = 1'b1;
    end

endmodule

// File: rtl/sramarb_m.sv
// rtl/sramarb_m.sv - two-requester ZBT SRAM arbiter top (SRAMARB_RR_EN selects round-robin)
module sramarb_m
    import sramarb_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [1:0]             bank,
    input  logic [1:0][A_SIZE-1:0] addr,
    input  logic [1:0][DQ_W-1:0]   wdata,
    output logic [1:0]             gnt,
    output logic                   rvalid,
    output logic                   rid,
    output logic [DQ_W-1:0]        rdata,
    output logic [A_SIZE-1:0]      A_A,
    output logic [A_SIZE-1:0]      A_B,
    output logic                   WE_n_A,
    output logic                   WE_n_B,
    output logic                   OE_n_A,
    output logic                   OE_n_B,
    output logic                   ADV_A,
    output logic                   ADV_B,
    output logic                   CE_n,
    output logic                   CE2,
    output logic                   CE2_n,
    output logic                   CKE_n,
    output logic                   ZZ,
    output logic                   FT_n,
    output logic                   MODE,
    output logic [3:0]             BW_n,
    output logic [DQ_W-1:0]        dq_out,
    output logic                   dq_oe,
    input  logic [DQ_W-1:0]        dq_in
);

    logic              accept;
    req_id_t           acc_id;
    pipe_stage_t       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [A_SIZE-1:0] a_a_q, a_a_d, a_b_q, a_b_d;
    logic              we_n_a_q, we_n_a_d, we_n_b_q, we_n_b_d;
    logic              rvalid_q, rvalid_d;
    req_id_t           rid_q, rid_d;
    logic [DQ_W-1:0]   rdata_q, rdata_d;
    logic              s3_rd, s3_wr;

    sramarb_sel_m u_sel (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .bank  (bank),
        .gnt   (gnt)
    );

    assign accept = |gnt;
    assign acc_id = gnt[1];

    // Accepted access loads stage 1 and the selected bank's address/WE_n pins
    always_comb begin
        s1_d     = '0;
        a_a_d    = a_a_q;
        a_b_d    = a_b_q;
        we_n_a_d = 1'b1;
        we_n_b_d = 1'b1;
        if (accept) begin
            s1_d.valid = 1'b1;
            s1_d.we    = we[acc_id];
            s1_d.bank  = bank[acc_id];
            s1_d.id    = acc_id;
            s1_d.wdata = wdata[acc_id];
            if (bank[acc_id]) begin
                a_b_d    = addr[acc_id];
                we_n_b_d = !we[acc_id];
            end else begin
                a_a_d    = addr[acc_id];
                we_n_a_d = !we[acc_id];
            end
        end
    end

    assign s3_rd = s3_q.valid && !s3_q.we;
    assign s3_wr = s3_q.valid &&  s3_q.we;

    // Pipeline advance and read-return capture (dq_in sampled at the end of the data cycle)
    always_comb begin
        s2_d     = s1_q;
        s3_d     = s2_q;
        rvalid_d = s3_rd;
        rid_d    = s3_rd ? s3_q.id : rid_q;
        rdata_d  = s3_rd ? dq_in : rdata_q;
    end

    // All state clears on reset so in-flight accesses never reach the bus or rvalid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            a_a_q    <= '0;
            a_b_q    <= '0;
            we_n_a_q <= 1'b1;
            we_n_b_q <= 1'b1;
            rvalid_q <= 1'b0;
            rid_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            a_a_q    <= a_a_d;
            a_b_q    <= a_b_d;
            we_n_a_q <= we_n_a_d;
            we_n_b_q <= we_n_b_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign A_A    = a_a_q;
    assign A_B    = a_b_q;
    assign WE_n_A = we_n_a_q;
    assign WE_n_B = we_n_b_q;
    assign ADV_A  = 1'b0;
    assign ADV_B  = 1'b0;

    // Data-cycle pins come straight from stage 3 flops
    assign OE_n_A = !(s3_rd && !s3_q.bank);
    assign OE_n_B = !(s3_rd &&  s3_q.bank);
    assign dq_oe  = s3_wr;
    assign dq_out = s3_wr ? s3_q.wdata : '0;
    assign BW_n   = s3_wr ? 4'b0000 : 4'b1111;

    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign rdata  = rdata_q;

    assign CE_n   = 1'b0;
    assign CE2    = 1'b1;
    assign CE2_n  = 1'b0;
    assign CKE_n  = 1'b0;
    assign ZZ     = 1'b0;
    assign FT_n   = 1'b1;
    assign MODE   = 1'b0;

endmodule
